// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared types, widths and node field layout for the decision-tree walker
package dtc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int FEAT_LSB     = 0;
   localparam int LEAF_VAL_LSB = 0;

   function automatic int feat_w(input int in_w);
      return $clog2(in_w);
   endfunction

   // Leaf flag on top of whichever payload is wider: leaf value or feature+two children.
   function automatic int node_w(input int in_w, input int out_w, input int aw);
      int payload;
      payload = feat_w(in_w) + 2 * aw;
      return 1 + ((out_w > payload) ? out_w : payload);
   endfunction

   function automatic int child0_lsb(input int fw);
      return fw;
   endfunction

   function automatic int child1_lsb(input int fw, input int aw);
      return fw + aw;
   endfunction

endpackage

// File: rtl/dtc_node_ram.sv
// rtl/dtc_node_ram.sv - node table, one sync write port, one async read port
module dtc_node_ram
   import dtc_pkg::*;
#(
   parameter int              AW      = 4,
   parameter int              NODE_W  = 12,
   parameter int              OUT_W   = 8,
   parameter logic [OUT_W-1:0] DEF_OUT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [NODE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [NODE_W-1:0] rdata
);

   localparam int DEPTH = 1 << AW;
   localparam logic [NODE_W-1:0] LEAF_RST =
      {1'b1, (NODE_W-1)'(DEF_OUT) << LEAF_VAL_LSB};

   logic [NODE_W-1:0] mem_q [DEPTH];

   // Reset wins over a coincident write so the table always comes up as DEF_OUT leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= LEAF_RST;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dtc_walker.sv
// rtl/dtc_walker.sv - decision-tree walker: one node per cycle from root to leaf, step-guarded
module dtc_walker
   import dtc_pkg::*;
#(
   parameter int               IN_W      = 8,
   parameter int               OUT_W     = 8,
   parameter int               AW        = 4,
   parameter int               MAX_STEPS = 2 ** AW,
   parameter logic [OUT_W-1:0] DEF_OUT   = '0,
   localparam int              FW        = feat_w(IN_W),
   localparam int              NODE_W    = node_w(IN_W, OUT_W, AW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   inp,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OUT_W-1:0]  outp,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [NODE_W-1:0] cfg_wdata,
   output logic              cfg_ready
);

   localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);
   localparam int XW = 1 << FW;
   localparam int C0 = child0_lsb(FW);
   localparam int C1 = child1_lsb(FW, AW);

   state_e            state_q, state_d;
   logic [IN_W-1:0]   inp_q, inp_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [SW-1:0]     step_q, step_d;
   logic [OUT_W-1:0]  outp_q, outp_d;
   logic              err_q, err_d;

   logic [NODE_W-1:0] node;
   logic              node_leaf;
   logic [FW-1:0]     node_feat;
   logic [AW-1:0]     node_c0, node_c1;
   logic [XW-1:0]     inp_x;
   logic              test_bit;
   logic              guard_hit;
   logic              idle;

   assign idle = (state_q == ST_IDLE);

   dtc_node_ram #(
      .AW      (AW),
      .NODE_W  (NODE_W),
      .OUT_W   (OUT_W),
      .DEF_OUT (DEF_OUT)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we & idle),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (addr_q),
      .rdata (node)
   );

   assign node_leaf = node[NODE_W-1];
   assign node_feat = node[FEAT_LSB +: FW];
   assign node_c0   = node[C0 +: AW];
   assign node_c1   = node[C1 +: AW];

   // Zero-extending to a power of two makes out-of-range feature indices read as 0.
   assign inp_x     = XW'(inp_q);
   assign test_bit  = inp_x[node_feat];
   assign guard_hit = !node_leaf && (step_q == STEP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         inp_q   <= '0;
         addr_q  <= '0;
         step_q  <= '0;
         outp_q  <= DEF_OUT;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         inp_q   <= inp_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         outp_q  <= outp_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)                 state_d = ST_WALK;
         ST_WALK: if (node_leaf || guard_hit)   state_d = ST_DONE;
         ST_DONE: if (out_ready)                state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      inp_d  = inp_q;
      addr_d = addr_q;
      step_d = step_q;
      outp_d = outp_q;
      err_d  = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               inp_d  = inp;
               addr_d = '0;
               step_d = '0;
            end
         end
         ST_WALK: begin
            if (node_leaf) begin
               outp_d = node[LEAF_VAL_LSB +: OUT_W];
               err_d  = 1'b0;
            end else if (guard_hit) begin
               outp_d = DEF_OUT;
               err_d  = 1'b1;
            end else begin
               addr_d = test_bit ? node_c1 : node_c0;
               step_d = step_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = idle;
      cfg_ready = idle;
      out_valid = (state_q == ST_DONE);
      outp      = outp_q;
      out_err   = err_q;
   end

endmodule

// File: tb/tb_dtc_walker.sv
// tb/tb_dtc_walker.sv - scoreboard bench for dtc_walker with directed tree programs
module tb_dtc_walker;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inp;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  outp;
   logic        out_err;
   logic        out_valid;
   logic        out_ready;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [11:0] cfg_wdata;
   logic        cfg_ready;

   always #5 clk = ~clk;

   dtc_walker dut (
      .clk       (clk),
      .rst       (rst),
      .inp       (inp),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .outp      (outp),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_ready (cfg_ready)
   );

   typedef struct {
      logic [7:0] outp;
      logic       err;
      int         lat;
      int         acc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   vec_n    = 0;
   int   miss_n   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   hold_n   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         miss_n++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] mk_int(input logic [2:0] f, input logic [3:0] c0,
                                          input logic [3:0] c1);
      return {1'b0, c1, c0, f};
   endfunction

   function automatic logic [11:0] mk_leaf(input logic [7:0] v);
      return {4'b1000, v};
   endfunction

   // Monitor: compares each presented result against the scoreboard, then consumes it.
   initial begin
      exp_t e;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && rst === 1'b0) begin
            if (sb.size() == 0) begin
               vec_n++;
               miss_n++;
               $display("FAIL unexpected_result: got outp %0h err %0b, want no result", outp, out_err);
            end else begin
               e = sb.pop_front();
               check({e.name, "_outp"}, 32'(outp), 32'(e.outp));
               check({e.name, "_err"}, 32'(out_err), 32'(e.err));
               check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
               for (int k = 0; k < hold_n; k++) begin
                  @(negedge clk);
                  check({e.name, "_hold_outp"}, 32'(outp), 32'(e.outp));
                  check({e.name, "_hold_err"}, 32'(out_err), 32'(e.err));
                  check({e.name, "_hold_valid"}, 32'(out_valid), 32'd1);
                  check({e.name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
               end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            done_cnt++;
         end
      end
   end

   task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   task automatic query(input string name, input logic [7:0] v, input logic [7:0] eo,
                        input logic ee, input int lat, input bit expect_it);
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         vec_n++;
         miss_n++;
         $display("FAIL %s_accept_timeout: in_ready %0b, want 1", name, in_ready);
      end
      if (expect_it) sb.push_back('{eo, ee, lat, cyc + 1, name});
      inp      = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      inp      = ~v;
   endtask

   task automatic wait_done(input string name, input int start);
      int t;
      t = 0;
      while (done_cnt == start && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == start) begin
         vec_n++;
         miss_n++;
         $display("FAIL %s_result_timeout: got no result, want one within 300 cycles", name);
         sb.delete();
      end
   endtask

   task automatic run(input string name, input logic [7:0] v, input logic [7:0] eo,
                      input logic ee, input int lat);
      int start;
      start = done_cnt;
      query(name, v, eo, ee, lat, 1'b1);
      wait_done(name, start);
   endtask

   initial begin
      int start;
      int t;
      rst       = 1'b1;
      inp       = '0;
      in_valid  = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_outp", 32'(outp), 32'h00);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

      run("post_rst", 8'h00, 8'h00, 1'b0, 1);

      cfg_write(4'd0, mk_int(3'd6, 4'd1, 4'd2));
      cfg_write(4'd1, mk_int(3'd4, 4'd3, 4'd4));
      cfg_write(4'd2, mk_leaf(8'h22));
      cfg_write(4'd3, mk_leaf(8'hB8));
      cfg_write(4'd4, mk_leaf(8'hF0));
      run("tree_00", 8'h00, 8'hB8, 1'b0, 3);
      run("tree_10", 8'h10, 8'hF0, 1'b0, 3);
      run("tree_40", 8'h40, 8'h22, 1'b0, 2);
      run("tree_af", 8'hAF, 8'hB8, 1'b0, 3);

      hold_n = 5;
      start  = done_cnt;
      query("hold", 8'h00, 8'hB8, 1'b0, 3, 1'b1);
      t = 0;
      while (out_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      cfg_we    = 1'b1;
      cfg_addr  = 4'd3;
      cfg_wdata = mk_leaf(8'h77);
      repeat (3) @(negedge clk);
      cfg_we = 1'b0;
      wait_done("hold", start);
      hold_n = 0;
      run("after_hold", 8'h00, 8'hB8, 1'b0, 3);

      cfg_write(4'd0, mk_int(3'd0, 4'd0, 4'd0));
      run("self_loop", 8'h01, 8'h00, 1'b1, 16);

      start     = done_cnt;
      cfg_we    = 1'b1;
      cfg_addr  = 4'd0;
      cfg_wdata = mk_leaf(8'h5A);
      query("same_edge_cfg", 8'h00, 8'h5A, 1'b0, 1, 1'b1);
      cfg_we = 1'b0;
      wait_done("same_edge_cfg", start);

      cfg_write(4'd0, mk_int(3'd6, 4'd1, 4'd2));
      query("rst_walk", 8'h00, 8'h00, 1'b0, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_walk_out_valid", 32'(out_valid), 32'd0);
      check("rst_walk_in_ready", 32'(in_ready), 32'd1);
      check("rst_walk_out_err", 32'(out_err), 32'd0);
      run("post_rst_walk_00", 8'h00, 8'h00, 1'b0, 1);
      run("post_rst_walk_50", 8'h50, 8'h00, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, want finish earlier");
      $fatal(1);
   end

endmodule

// File: doc/dtc_walker.md
DTC_WALKER -- requirements
Module: dtc_walker

Interface
REQ-001 Parameter IN_W, default 8: width of the feature vector inp.
REQ-002 Parameter OUT_W, default 8: width of the class/leaf value outp.
REQ-003 Parameter AW, default 4: node-address width; node table holds 2**AW entries.
REQ-004 Parameter MAX_STEPS, default 2**AW: maximum nodes visited per query before abort.
REQ-005 Parameter DEF_OUT, default all-zero: value output on abort and stored in every leaf after reset.
REQ-006 Ports, name direction width meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- inp  in  IN_W  feature vector.
- in_valid  in  1  query present.
- in_ready  out  1  query accepted when in_valid&in_ready.
- outp  out  OUT_W  leaf value.
- out_err  out  1  query aborted by step guard.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid&out_ready.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  AW  node index.
- cfg_wdata  in  NODE_W  node entry.
- cfg_ready  out  1  write accepted when cfg_we&cfg_ready.

Function
REQ-007 NODE_W SHALL be 1+max(OUT_W, FW+2*AW), with FW=clog2(IN_W); MSB is leaf flag.
REQ-008 Leaf entry (MSB=1): bits [OUT_W-1:0] are the leaf value; other bits ignored.
REQ-009 Internal entry (MSB=0): bits [FW-1:0] feature index f; [FW+AW-1:FW] child taken when inp[f]=0; [FW+2*AW-1:FW+AW] child taken when inp[f]=1.
REQ-010 Feature index f>=IN_W SHALL test as 0.
REQ-011 States: IDLE, WALK, DONE; in_ready=cfg_ready=(state==IDLE).
REQ-012 IDLE: on in_valid, register inp, node address<=0, step count<=0, go WALK.
REQ-013 WALK: read current node combinationally each cycle; internal node -> address<=selected child, step+1; leaf -> outp<=value, out_err<=0, go DONE.
REQ-014 Latency: leaf at depth d (root depth 0) SHALL raise out_valid exactly d+1 edges after the accepting edge.
REQ-015 Step guard: internal node seen with step count==MAX_STEPS-1 -> outp<=DEF_OUT, out_err<=1, go DONE.
REQ-016 DONE: out_valid=1; outp/out_err held stable until out_ready; on out_ready go IDLE (next query accepted no earlier than following edge).
REQ-017 Config write in IDLE commits at the clock edge; a query accepted on the same edge SHALL traverse the updated table.
REQ-018 cfg_we outside IDLE SHALL be ignored (no table change).
REQ-019 Registered inp SHALL not change during WALK/DONE regardless of inp pin.

Reset
REQ-020 rst SHALL force state IDLE, out_valid=0, out_err=0, outp=DEF_OUT, step count 0.
REQ-021 rst SHALL set every node entry to leaf with value DEF_OUT.
REQ-022 rst mid-WALK or mid-DONE SHALL abort the query with no result; rst has priority over cfg_we.

Structure
REQ-023 Package dtc_pkg SHALL hold the state enum, NODE_W/FW width functions and leaf/feature/child field-offset constants.
REQ-024 Node table SHALL be sub-module dtc_node_ram (one sync write port, one async read port, reset-to-leaf).

Verification
REQ-025 Post-reset query inp=8'h00 -> out_valid after 1 edge, outp=DEF_OUT, out_err=0.
REQ-026 Program root: test bit6, children 1/2; node1: test bit4, children 3/4; node3 leaf 8'hB8; inp=8'h00 -> outp=8'hB8 after 3 edges; inp=8'h10 with node4 leaf 8'hF0 -> 8'hF0.
REQ-027 Node0 internal feature0, both children 0 (self-loop) -> after MAX_STEPS=16 edges out_err=1, outp=DEF_OUT.
REQ-028 Hold out_ready=0 for 5 cycles in DONE -> outp, out_err, out_valid stable; in_ready=0; cfg_we ignored (table readback query unchanged).
REQ-029 cfg_we rewriting node0 to leaf 8'h5A on same edge as query accept -> result 8'h5A.
REQ-030 Assert rst during WALK -> next edge out_valid=0, in_ready=1, table reset to DEF_OUT leaves.
